// File: rtl/mult_sched_pkg.sv
// Shared types and widths for the shared-multiplier scheduler.
package mult_sched_pkg;

  localparam int unsigned OP_W  = 16;
  localparam int unsigned RES_W = 32;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/mult_sched_if.sv
// Requester, multiplier and response signals of the scheduler.
interface mult_sched_if
  import mult_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);

  logic                    Run;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*OP_W-1:0] req_a;
  logic [NUM_REQ*OP_W-1:0] req_b;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    mul_valid;
  logic [OP_W-1:0]         mul_a;
  logic [OP_W-1:0]         mul_b;
  logic [RES_W-1:0]        mul_result;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [RES_W-1:0]        rsp_result;
  logic                    busy;
  logic [15:0]             ops_count;

  modport master (
    output Run, req_valid, req_a, req_b, mul_result,
    input  req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_result, busy, ops_count
  );

  modport slave (
    input  Run, req_valid, req_a, req_b, mul_result,
    output req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_result, busy, ops_count
  );

endinterface

// File: rtl/mult_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant_c,
  output logic [IDX_W-1:0]   o_idx_c,
  output logic               o_any_c
);

  // Scan offsets from the pointer; the first hit wins and blocks later ones.
  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_any_c   = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (i_en && !o_any_c && i_req[i] &&
            (((32'(i_ptr) + off) % NUM_REQ) == i)) begin
          o_any_c      = 1'b1;
          o_idx_c      = IDX_W'(i);
          o_grant_c[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Shares one pipelined multiplier among NUM_REQ requesters; tags track ownership.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  mult_sched_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_ISSUE = 2'(ISSUE);
  localparam logic [1:0] S_DRAIN = 2'(DRAIN);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic               r_mul_valid;
  logic [OP_W-1:0]    r_mul_a;
  logic [OP_W-1:0]    r_mul_b;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [RES_W-1:0]   r_rsp_result;
  logic [15:0]        r_ops;
  tag_t               r_tag [MUL_LATENCY+1];

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_grant_any;
  logic               w_issue_en;
  logic [OP_W-1:0]    w_a;
  logic [OP_W-1:0]    w_b;
  logic               w_pipe_any;
  logic [NUM_REQ-1:0] w_rsp_oh;
  logic [IDX_W-1:0]   w_ptr_nxt;

  assign w_issue_en = (r_state == S_ISSUE);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req     (bus.req_valid),
    .i_ptr     (r_ptr),
    .i_en      (w_issue_en),
    .o_grant_c (w_grant),
    .o_idx_c   (w_grant_idx),
    .o_any_c   (w_grant_any)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_a = bus.req_a[i*OP_W +: OP_W];
        w_b = bus.req_b[i*OP_W +: OP_W];
      end
    end
  end

  assign w_ptr_nxt = (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                          : IDX_W'(w_grant_idx + IDX_W'(1));

  always_comb begin
    w_pipe_any = 1'b0;
    for (int unsigned j = 0; j <= MUL_LATENCY; j++) begin
      w_pipe_any = w_pipe_any | r_tag[j].valid;
    end
  end

  // The last tag stage lines up with the cycle mul_result is valid.
  always_comb begin
    w_rsp_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_tag[MUL_LATENCY].valid && (r_tag[MUL_LATENCY].idx == IDX_W'(i))) begin
        w_rsp_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.Run) w_state_nxt = S_ISSUE;
      S_ISSUE: if (!bus.Run) w_state_nxt = (w_grant_any || w_pipe_any) ? S_DRAIN : S_IDLE;
      S_DRAIN: begin
        if (bus.Run)          w_state_nxt = S_ISSUE;
        else if (!w_pipe_any) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_mul_valid  <= 1'b0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_ops        <= '0;
      for (int unsigned j = 0; j <= MUL_LATENCY; j++) begin
        r_tag[j] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_mul_valid <= w_grant_any;
      if (w_grant_any) begin
        r_mul_a <= w_a;
        r_mul_b <= w_b;
        r_ptr   <= w_ptr_nxt;
      end
      r_tag[0] <= tag_t'{valid: w_grant_any, idx: w_grant_idx};
      for (int unsigned j = 1; j <= MUL_LATENCY; j++) begin
        r_tag[j] <= r_tag[j-1];
      end
      r_rsp_valid <= w_rsp_oh;
      if (r_tag[MUL_LATENCY].valid) begin
        r_rsp_result <= bus.mul_result;
        if (r_ops != 16'hFFFF) r_ops <= r_ops + 16'd1;
      end
    end
  end

  assign bus.req_ready  = w_grant;
  assign bus.mul_valid  = r_mul_valid;
  assign bus.mul_a      = r_mul_a;
  assign bus.mul_b      = r_mul_b;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.ops_count  = r_ops;
  assign bus.busy       = (r_state != S_IDLE) | w_pipe_any;

endmodule

// File: doc/mult_sched.md
Name: mult_sched

Overview:
- Shares one pipelined 16x16 unsigned Wallace-tree multiplier among NUM_REQ requesters.
- Arbitrates round-robin, issues at most one operand pair per cycle, and tracks in-flight requester tags through a shift pipeline matched to the multiplier latency.
- Routes each product back to its originating requester.
- Sits between the multiplier datapath and the client blocks; gated by Run.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MUL_LATENCY, 2, cycles from mul_valid to valid mul_result (1..8)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Run  in  1  enable issuing; low = stop granting, drain in-flight
req_valid  in  NUM_REQ  per-requester operation request
req_a  in  NUM_REQ*16  multiplicand per requester, slice i = bits [16i+15:16i]
req_b  in  NUM_REQ*16  multiplier per requester, same slicing
req_ready  out  NUM_REQ  one-hot grant, combinational from req_valid, Run, state, rr pointer
mul_valid  out  1  operands valid to multiplier this cycle
mul_a  out  16  operand to multiplier (MUD side)
mul_b  out  16  operand to multiplier (MUR side)
mul_result  in  32  product from multiplier
rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: product for requester i
rsp_result  out  32  product accompanying rsp_valid
busy  out  1  any operation in flight or being issued
ops_count  out  16  completed operations, saturating

Behaviour:
- Reset (async, any time): all outputs 0; rr pointer 0; tag pipeline cleared; state IDLE.
  - In-flight operations are discarded; no rsp_valid is ever produced for them.
- States:
  - IDLE: Run=1 -> ISSUE.
  - ISSUE: Run=0 -> DRAIN if pipeline non-empty, else IDLE.
  - DRAIN: no grants; pipeline empty -> IDLE; Run=1 while draining -> ISSUE.
- Grant:
  - Only in ISSUE. req_ready = one-hot of the first valid requester at or after rr pointer, wrapping NUM_REQ-1 -> 0.
  - Handshake = req_valid[i] & req_ready[i] at a rising edge. Requester must hold its operands until then.
- On handshake at edge k:
  - mul_valid=1, mul_a=req_a[i], mul_b=req_b[i] registered after edge k.
  - Tag i enters the pipeline.
  - rr pointer becomes (i+1) mod NUM_REQ.
  - No handshake -> mul_valid=0 next cycle; operand regs hold their value.
- Multiplier contract: mul_result is valid in the cycle after edge k+MUL_LATENCY.
- Response: rsp_valid[i]=1 and rsp_result=mul_result registered at edge k+MUL_LATENCY+1, for one cycle. No backpressure.
  - Otherwise rsp_valid=0 and rsp_result holds its last value.
- Throughput: one op per cycle sustained. With all requesters valid, grants rotate 0,1,2,3,0,...
- Same requester may have multiple ops in flight; responses return in issue order.
- ops_count increments on each rsp_valid pulse and saturates at 0xFFFF.
- busy = (state != IDLE) | any tag pipeline stage valid.
- Arithmetic: unsigned, full 32-bit product, no truncation.
- Simultaneous events:
  - Run falling in the same cycle as a request: the grant still completes that cycle; DRAIN starts next.
  - Reset has priority over all events.

Decomposition:
- mult_pkg:
  - OP_W=16, RES_W=32.
  - sched_state_t enum {IDLE, ISSUE, DRAIN}.
  - tag_t typedef: struct {valid, idx[2:0]}.
- Sub-module rr_arbiter:
  - Parameterized NUM_REQ.
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; pointer register is held in mult_sched.

Test Plan:
- Single op: Run=1, req_valid[0], a=3, b=2 -> req_ready[0] same cycle; rsp_valid[0]=1, rsp_result=6 exactly MUL_LATENCY+1 edges after handshake; ops_count=1.
- Round-robin: all 4 requesters valid with a=i+1, b=10 -> grants 0,1,2,3,0 on consecutive cycles; responses 10,20,30,40 in order with matching one-hot rsp_valid.
- Boundary: a=0xFFFF, b=0xFFFF -> 0xFFFE0001; a=0, b=0x1234 -> 0.
- Run drop: issue 2 ops, drop Run the next cycle with requests pending -> no further req_ready; both rsp delivered; busy falls after last rsp; state IDLE.
- Reset mid-flight: handshake at edge k, assert Reset before edge k+MUL_LATENCY+1 -> no rsp_valid ever; all outputs 0; ops_count 0; a new op after release completes normally.
- Saturation and pointer wrap: force 0x10000 completions -> ops_count stays 0xFFFF. Requester 3 alone, then requester 0 alone -> pointer wraps, 0 granted.
